seq_ctx_sched: RTL

- Time-multiplexes one 4-state bit-serial Mealy engine (input C, output Y) across N_CH independent input streams.
- Per-channel 2-bit state contexts are held in a register file.
- A round-robin arbiter grants at most one channel per cycle. The shared engine loads that channel's context, computes next state and Y, writes the context back, and returns Y on a registered response port.
- Sits between the serial-bit producers and the shared detector logic, so one engine replaces N_CH copies.

---
 rtl/seq_ctx_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/seq_ctx_sched.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_ctx_pkg.sv
// Shared state encoding and transition table for the bit-serial Mealy engine.
// Used by the scheduler RTL; one place defines the next-state/output rule.
package seq_ctx_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ONE  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_ZERO = 2'b11;

  // Returns {next_state, y}; y depends only on the pre-update state and c.
  function automatic logic [2:0] seq_next(input logic [1:0] s, input logic c);
    logic [1:0] ns;
    case (s)
      S_IDLE:  ns = c ? S_ONE  : S_IDLE;
      S_ONE:   ns = c ? S_ONE  : S_ZERO;
      S_HOLD:  ns = c ? S_HOLD : S_IDLE;
      default: ns = c ? S_HOLD : S_ZERO;
    endcase
    return {ns, c & s[1]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer, zero when en=0.
// Combinational grant; pointer advances past the winner at the clock edge.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] ptr_q, ptr_d;
  logic         found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !found && req[(int'(ptr_q) + k) % N]) begin
        found   = 1'b1;
        gnt_idx = W'((int'(ptr_q) + k) % N);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/seq_ctx_sched.sv
// Shares one Mealy engine across N_CH bit streams with per-channel contexts.
// One bit per cycle; result registered one cycle after grant; grants stall while the response is held.
module seq_ctx_sched
  import seq_ctx_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_valid,
  input  logic [N_CH-1:0] req_c,
  output logic [N_CH-1:0] req_ready,
  input  logic [N_CH-1:0] ch_clr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [CH_W-1:0] rsp_ch,
  output logic            rsp_y,
  output logic [1:0]      rsp_state
);

  logic [1:0]      ctx_q [N_CH];
  logic [1:0]      ctx_d [N_CH];
  logic            rsp_valid_q, rsp_valid_d;
  logic [CH_W-1:0] rsp_ch_q, rsp_ch_d;
  logic            rsp_y_q, rsp_y_d;
  logic [1:0]      rsp_state_q, rsp_state_d;

  logic            can_issue;
  logic            any_gnt;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gnt_idx;
  logic [1:0]      cur_s;
  logic [2:0]      eng;

  assign can_issue = ~rsp_valid_q | rsp_ready;

  rr_arbiter #(.N(N_CH), .W(CH_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (can_issue),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign any_gnt   = |gnt;

  always_comb begin
    // A clear on the granted channel takes effect before the engine sees the bit.
    cur_s = ch_clr[gnt_idx] ? S_IDLE : ctx_q[gnt_idx];
    eng   = seq_next(cur_s, req_c[gnt_idx]);

    for (int i = 0; i < N_CH; i++) begin
      ctx_d[i] = ch_clr[i] ? S_IDLE : ctx_q[i];
    end
    if (any_gnt) ctx_d[gnt_idx] = eng[2:1];

    rsp_valid_d = rsp_valid_q;
    rsp_ch_d    = rsp_ch_q;
    rsp_y_d     = rsp_y_q;
    rsp_state_d = rsp_state_q;
    if (any_gnt) begin
      rsp_valid_d = 1'b1;
      rsp_ch_d    = gnt_idx;
      rsp_y_d     = eng[0];
      rsp_state_d = eng[2:1];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) ctx_q[i] <= S_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_y_q     <= 1'b0;
      rsp_state_q <= S_IDLE;
    end else begin
      ctx_q       <= ctx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_y_q     <= rsp_y_d;
      rsp_state_q <= rsp_state_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_ch_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_state = rsp_state_q;

endmodule
